alu_commit_buffer: RTL and testbench

In-order commit buffer for the out-of-order core. It allocates instruction IDs at dispatch, in program order. It captures completed results returned out of order by the multi-cycle ALUs (their `valid` / delayed result / rd / instruction ID outputs) and retires them to the register file strictly in allocation order, one per cycle. It sits between the ALU result buses and the register-file write port, and it is the consumer end of the ALU completion interface.

---
 rtl/alu_commit_buffer.sv | 147 ++++++++++++++
 tb/tb_alu_commit_buffer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_commit_buffer.sv
// In-order commit buffer: allocates IDs, captures out-of-order ALU results,
// retires strictly in allocation order. Optional macro: COMMIT_BYPASS_EN.
module alu_commit_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_BITS    = 5,
  parameter int ID_BITS    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  alloc_req,
  input  logic [RD_BITS-1:0]    alloc_rd,
  output logic                  alloc_grant,
  output logic [ID_BITS-1:0]    alloc_id,
  output logic                  full,
  output logic                  empty,
  input  logic                  result_valid,
  input  logic [ID_BITS-1:0]    result_id,
  input  logic [DATA_WIDTH-1:0] result_data,
  input  logic                  result_branch,
  output logic                  commit_valid,
  output logic                  commit_we,
  output logic [RD_BITS-1:0]    commit_rd,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic                  commit_branch,
  output logic                  protocol_error
);

  localparam int ENTRIES = 2 ** ID_BITS;
  localparam logic [ID_BITS:0] FULL_COUNT = ENTRIES[ID_BITS:0];

  logic [ENTRIES-1:0]    alloc_q;
  logic [ENTRIES-1:0]    done_q;
  logic [RD_BITS-1:0]    rd_q     [ENTRIES];
  logic [DATA_WIDTH-1:0] data_q   [ENTRIES];
  logic                  branch_q [ENTRIES];

  logic [ID_BITS-1:0] head_q;
  logic [ID_BITS-1:0] tail_q;
  logic [ID_BITS:0]   count_q;

  logic result_live;
  logic result_ok;
  logic result_bad;
  logic bypass;
  logic complete;
  logic stored_commit;
  logic commit_fire;
  logic [RD_BITS-1:0]    sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_branch;

  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign alloc_id    = tail_q;
  assign alloc_grant = alloc_req & ~full & ~flush;

  // A result in a flush cycle is discarded silently.
  assign result_live = result_valid & ~flush;
  assign result_ok   = result_live & alloc_q[result_id] & ~done_q[result_id];
  assign result_bad  = result_live & (~alloc_q[result_id] | done_q[result_id]);

`ifdef COMMIT_BYPASS_EN
  // A result for the waiting head retires directly, skipping the done state.
  assign bypass = result_ok & (result_id == head_q);
`else
  assign bypass = 1'b0;
`endif

  assign complete      = result_ok & ~bypass;
  assign stored_commit = ~flush & alloc_q[head_q] & done_q[head_q];
  assign commit_fire   = stored_commit | bypass;

  assign sel_rd     = rd_q[head_q];
  assign sel_data   = bypass ? result_data : data_q[head_q];
  assign sel_branch = bypass ? result_branch : branch_q[head_q];

  // Entry status bits and pointers.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      alloc_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (commit_fire) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (complete) begin
        done_q[result_id] <= 1'b1;
      end
      if (alloc_grant) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_q + {{ID_BITS{1'b0}}, alloc_grant}
                         - {{ID_BITS{1'b0}}, commit_fire};
    end
  end

  // Entry payload; validity is tracked by the status bits above.
  always_ff @(posedge clock) begin
    if (alloc_grant) begin
      rd_q[tail_q] <= alloc_rd;
    end
    if (complete) begin
      data_q[result_id]   <= result_data;
      branch_q[result_id] <= result_branch;
    end
  end

  // Register-file write port, one retired entry per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      commit_valid  <= 1'b0;
      commit_we     <= 1'b0;
      commit_rd     <= '0;
      commit_data   <= '0;
      commit_branch <= 1'b0;
    end else if (flush) begin
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
    end else begin
      commit_valid <= commit_fire;
      commit_we    <= commit_fire & (sel_rd != '0);
      if (commit_fire) begin
        commit_rd     <= sel_rd;
        commit_data   <= sel_data;
        commit_branch <= sel_branch;
      end
    end
  end

  // Sticky flag for results aimed at free or already-completed entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if (result_bad) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_commit_buffer.sv
// Directed testbench for alu_commit_buffer.
// Honours COMMIT_BYPASS_EN for the latency-dependent scenarios.
module tb_alu_commit_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        alloc_req;
  logic [4:0]  alloc_rd;
  logic        alloc_grant;
  logic [1:0]  alloc_id;
  logic        full;
  logic        empty;
  logic        result_valid;
  logic [1:0]  result_id;
  logic [31:0] result_data;
  logic        result_branch;
  logic        commit_valid;
  logic        commit_we;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        commit_branch;
  logic        protocol_error;

  int checks = 0;
  int failures = 0;

  logic [4:0]  q_rd [$];
  logic [31:0] q_data [$];
  logic        q_we [$];

  alu_commit_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .alloc_req      (alloc_req),
    .alloc_rd       (alloc_rd),
    .alloc_grant    (alloc_grant),
    .alloc_id       (alloc_id),
    .full           (full),
    .empty          (empty),
    .result_valid   (result_valid),
    .result_id      (result_id),
    .result_data    (result_data),
    .result_branch  (result_branch),
    .commit_valid   (commit_valid),
    .commit_we      (commit_we),
    .commit_rd      (commit_rd),
    .commit_data    (commit_data),
    .commit_branch  (commit_branch),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (commit_valid === 1'b1) begin
      q_rd.push_back(commit_rd);
      q_data.push_back(commit_data);
      q_we.push_back(commit_we);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    q_rd.delete();
    q_data.delete();
    q_we.delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    alloc_req = 1'b1;
    alloc_rd  = rd;
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic result(input logic [1:0] id, input logic [31:0] d);
    result_valid = 1'b1;
    result_id    = id;
    result_data  = d;
    tick();
    result_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags empty=%b full=%b want 1/0", empty, full);
    end
    checks++;
    if (commit_valid !== 1'b0 || commit_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_commit valid=%b we=%b want 0/0",
               commit_valid, commit_we);
    end
    checks++;
    if (alloc_id !== 2'd0 || protocol_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_id_err id=%0d err=%b want 0/0",
               alloc_id, protocol_error);
    end
  endtask

  task automatic test_in_order();
    logic [4:0]  exp_rd [3];
    logic [31:0] exp_d [3];
    logic        exp_we [3];
    exp_rd = '{5'd5, 5'd6, 5'd0};
    exp_d  = '{32'h11, 32'h22, 32'h33};
    exp_we = '{1'b1, 1'b1, 1'b0};
    clear_q();
    alloc_req = 1'b1;
    alloc_rd  = 5'd5;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_id !== 2'd0) begin
      failures++;
      $display("FAIL inorder_grant grant=%b id=%0d want 1/0",
               alloc_grant, alloc_id);
    end
    tick();
    alloc_req = 1'b0;
    alloc(5'd6);
    alloc(5'd0);
    result(2'd2, 32'h33);
    tick();
    tick();
    checks++;
    if (q_rd.size() != 0) begin
      failures++;
      $display("FAIL inorder_blocked commits=%0d want 0", q_rd.size());
    end
    result(2'd0, 32'h11);
    result(2'd1, 32'h22);
    repeat (4) tick();
    checks++;
    if (q_rd.size() != 3) begin
      failures++;
      $display("FAIL inorder_count commits=%0d want 3", q_rd.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_rd[i] !== exp_rd[i] || q_data[i] !== exp_d[i]
            || q_we[i] !== exp_we[i]) begin
          failures++;
          $display("FAIL inorder_commit%0d rd=%0d d=%h we=%b want %0d/%h/%b",
                   i, q_rd[i], q_data[i], q_we[i],
                   exp_rd[i], exp_d[i], exp_we[i]);
        end
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL inorder_empty empty=%b want 1", empty);
    end
  endtask

  task automatic test_full_wrap();
    do_flush();
    clear_q();
    for (int i = 1; i <= 4; i++) alloc(5'(i));
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL wrap_full full=%b want 1", full);
    end
    alloc_req = 1'b1;
    alloc_rd  = 5'd9;
    #1;
    checks++;
    if (alloc_grant !== 1'b0) begin
      failures++;
      $display("FAIL wrap_nogrant grant=%b want 0", alloc_grant);
    end
    tick();
    alloc_req = 1'b0;
    result(2'd0, 32'h44);
    for (int i = 0; i < 4 && full === 1'b1; i++) tick();
    tick();
    checks++;
    if (full !== 1'b0 || q_rd.size() != 1) begin
      failures++;
      $display("FAIL wrap_free full=%b commits=%0d want 0/1",
               full, q_rd.size());
    end else begin
      checks++;
      if (q_rd[0] !== 5'd1 || q_data[0] !== 32'h44) begin
        failures++;
        $display("FAIL wrap_commit rd=%0d d=%h want 1/44",
                 q_rd[0], q_data[0]);
      end
    end
    alloc_req = 1'b1;
    alloc_rd  = 5'd12;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_id !== 2'd0) begin
      failures++;
      $display("FAIL wrap_id grant=%b id=%0d want 1/0", alloc_grant, alloc_id);
    end
    tick();
    alloc_req = 1'b0;
    checks++;
    if (full !== 1'b1 || protocol_error !== 1'b0) begin
      failures++;
      $display("FAIL wrap_refull full=%b err=%b want 1/0",
               full, protocol_error);
    end
  endtask

  task automatic test_back_to_back();
    do_flush();
    clear_q();
    alloc(5'd7);
    alloc(5'd8);
`ifndef COMMIT_BYPASS_EN
    result(2'd0, 32'h55);
`endif
    alloc_req = 1'b1;
    alloc_rd  = 5'd9;
`ifdef COMMIT_BYPASS_EN
    result_valid = 1'b1;
    result_id    = 2'd0;
    result_data  = 32'h55;
`endif
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_id !== 2'd2) begin
      failures++;
      $display("FAIL b2b_grant grant=%b id=%0d want 1/2", alloc_grant, alloc_id);
    end
    tick();
    alloc_req    = 1'b0;
    result_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd7
        || commit_data !== 32'h55) begin
      failures++;
      $display("FAIL b2b_commit v=%b rd=%0d d=%h want 1/7/55",
               commit_valid, commit_rd, commit_data);
    end
    checks++;
    if (alloc_id !== 2'd3 || empty !== 1'b0 || full !== 1'b0) begin
      failures++;
      $display("FAIL b2b_state id=%0d empty=%b full=%b want 3/0/0",
               alloc_id, empty, full);
    end
    alloc(5'd10);
    checks++;
    if (full !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count3 full=%b want 0", full);
    end
    alloc(5'd11);
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL b2b_count4 full=%b want 1", full);
    end
  endtask

  task automatic test_latency();
    do_flush();
    result_valid = 1'b1;
    result_id    = 2'd1;
    result_data  = 32'h77;
    do_flush();
    result_valid = 1'b0;
    checks++;
    if (protocol_error !== 1'b0 || commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_result err=%b v=%b want 0/0",
               protocol_error, commit_valid);
    end
    alloc(5'd12);
    result(2'd0, 32'hAB);
`ifndef COMMIT_BYPASS_EN
    checks++;
    if (commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_early v=%b want 0", commit_valid);
    end
    tick();
`endif
    checks++;
    if (commit_valid !== 1'b1 || commit_we !== 1'b1
        || commit_rd !== 5'd12 || commit_data !== 32'hAB) begin
      failures++;
      $display("FAIL lat_commit v=%b we=%b rd=%0d d=%h want 1/1/12/ab",
               commit_valid, commit_we, commit_rd, commit_data);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL lat_pulse v=%b empty=%b want 0/1", commit_valid, empty);
    end
  endtask

  task automatic test_protocol_error();
    do_flush();
    result(2'd3, 32'h99);
    checks++;
    if (protocol_error !== 1'b1) begin
      failures++;
      $display("FAIL perr_set err=%b want 1", protocol_error);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0 || empty !== 1'b1 || alloc_id !== 2'd0) begin
      failures++;
      $display("FAIL perr_state v=%b empty=%b id=%0d want 0/1/0",
               commit_valid, empty, alloc_id);
    end
    alloc(5'd3);
    do_flush();
    checks++;
    if (protocol_error !== 1'b1 || empty !== 1'b1) begin
      failures++;
      $display("FAIL perr_flush err=%b empty=%b want 1/1",
               protocol_error, empty);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (protocol_error !== 1'b0 || commit_rd !== 5'd0
        || commit_data !== 32'd0) begin
      failures++;
      $display("FAIL perr_reset err=%b rd=%0d d=%h want 0/0/0",
               protocol_error, commit_rd, commit_data);
    end
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    alloc_req     = 1'b0;
    alloc_rd      = '0;
    result_valid  = 1'b0;
    result_id     = '0;
    result_data   = '0;
    result_branch = 1'b0;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_back_to_back();
    test_latency();
    test_protocol_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
